fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction queue between the IF stage and the ID stage. Decouples cache-miss fetch bubbles from decode hazard stalls. Accepts each buffered word the IF stage presents (instruction, fetch PC) and holds up to DEPTH entries in order. Presents them to ID with a valid/ready handshake; a control-flow redirect flushes every entry.

## Interface
- DEPTH, 2: queue entries; power of two, legal range 2..8.
- NOP_INST, 32'h00000013: value driven on o_id_inst whenever o_id_valid is low.

Ports:
- i_clk  in  1  global clock, all state on rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_if_valid  in  1  IF presents a buffered instruction
- i_if_inst  in  32  instruction word from IF
- i_if_pc  in  32  fetch PC of i_if_inst
- o_if_stall  out  1  queue full; drives IF stall-PC input, IF holds its word
- i_flush  in  1  PC redirect from ID/EX; discard all queued and incoming words
- o_id_valid  out  1  head entry valid for decode
- o_id_inst  out  32  head instruction
- o_id_pc  out  32  head PC
- o_id_pc_plus_4  out  32  o_id_pc + 4, modulo 2^32
- i_id_ready  in  1  ID consumes head this cycle (low during hazard stall)
- o_count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH-entry circular array of {inst, pc}. Write pointer and read pointer are $clog2(DEPTH) bits wide and wrap naturally. The occupancy counter is a separate register.
- push = i_if_valid && !o_if_stall && !i_flush.
- pop = o_id_valid && i_id_ready.
- o_if_stall = (count == DEPTH). It is registered-state only, with no combinational path from i_id_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any occupancy below DEPTH.
- Full and pop in the same cycle: no push that cycle, because stall was already high. Stall drops in the next cycle.
- Empty: o_id_valid = 0, o_id_inst = NOP_INST, o_id_pc = 0, o_id_pc_plus_4 = 4.
- o_id_valid = (count != 0) && !i_flush. A flushing cycle never presents a valid word to ID.
- Flush: on the next edge, count = 0 and read pointer = write pointer. The incoming IF word in the flush cycle is dropped, and pop is suppressed. Flush has priority over push and pop.
- Stored entries are not cleared on flush; only the pointers and count change.
- The queue never reorders, duplicates or drops a word except on flush.

## Timing
- Reset (i_rst_n low, asynchronous): pointers = 0, count = 0. All storage entries are set to {NOP_INST, 32'h0}.
- Outputs during reset: o_id_valid = 0, o_if_stall = 0, o_count = 0.
- Deassertion of reset is taken synchronously at the next edge (an external synchronizer provides this).
- Reset asserted mid-operation: all queued words are lost immediately, and outputs take their reset values without waiting for a clock.
- Latency without bypass: a word pushed at edge N is visible on o_id_* after edge N (a 1-cycle minimum).
- Throughput: one push and one pop per cycle sustained.
- o_if_stall rises in the cycle after the push that fills the queue. It falls in the cycle after the first pop from full.

## Configuration
- FETCH_BUFFER_BYPASS_EN defined:
  - When count == 0 and i_if_valid && !i_flush, o_id_* are driven combinationally from the i_if_* inputs and o_id_valid = 1 (zero-cycle latency).
  - If i_id_ready is also high, the word is consumed and not written.
  - If i_id_ready is low, the word is written normally.
- FETCH_BUFFER_BYPASS_EN undefined: outputs come only from storage, and the empty queue always adds one cycle of latency. This is the default build.

## Test plan
- Reset then stream: push PCs 0x0, 0x4, 0x8 with i_id_ready = 1 every cycle -> o_id_pc shows 0x0, 0x4, 0x8 on consecutive cycles, each one cycle after its push (same cycle with bypass). o_count never exceeds 1.
- Fill (DEPTH = 2): i_id_ready = 0, push 0x100 and 0x104 -> o_count = 2 and o_if_stall = 1.
  - The third word 0x108, held by IF, is not taken.
  - Raise i_id_ready for one cycle -> 0x100 pops, stall drops next cycle, 0x108 enters; order out is 0x100, 0x104, 0x108.
- Pointer wrap: 10 push/pop cycles at occupancy 1 -> no loss. o_id_pc_plus_4 = o_id_pc + 4 at each step.
- Flush with 2 queued plus an incoming word: assert i_flush -> o_id_valid = 0 that cycle, and o_count = 0 the next cycle.
  - The next pushed word, 0x200, is the next word delivered.
- Asynchronous reset mid-stream: drop i_rst_n between edges with 2 entries queued -> o_id_valid = 0, o_count = 0, o_id_inst = 32'h00000013 before the next edge.
- PC wrap: push pc 0xFFFFFFFC -> o_id_pc_plus_4 = 0x00000000.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer -- instruction queue between the IF and ID stages.
//
// Holds up to DEPTH {instruction, fetch PC} words in arrival order and hands
// them to ID over a valid/ready handshake. A control-flow redirect (i_flush)
// discards every queued word and the word IF presents in the same cycle.
//
// Optional feature macro: FETCH_BUFFER_BYPASS_EN
//   defined   -> an empty queue forwards the IF word combinationally to ID
//                (zero-cycle latency); the word is stored only if ID stalls.
//   undefined -> (default) ID always sees registered storage, so an empty
//                queue adds one cycle of latency.
//
// Parameters:
//   DEPTH     queue entries, power of two, 2..8
//   NOP_INST  instruction driven on o_id_inst while o_id_valid is low
//
// Ports:
//   i_clk           clock, all state on the rising edge
//   i_rst_n         asynchronous active-low reset
//   i_if_valid      IF presents a word
//   i_if_inst       instruction word from IF
//   i_if_pc         fetch PC of i_if_inst
//   o_if_stall      queue full; IF holds its word
//   i_flush         PC redirect; drop all queued and incoming words
//   o_id_valid      head word valid for decode
//   o_id_inst       head instruction
//   o_id_pc         head PC
//   o_id_pc_plus_4  o_id_pc + 4 (wraps modulo 2^32)
//   i_id_ready      ID consumes the head this cycle
//   o_count         current occupancy
module fetch_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_if_valid,
  input  logic [31:0]                i_if_inst,
  input  logic [31:0]                i_if_pc,
  output logic                       o_if_stall,
  input  logic                       i_flush,
  output logic                       o_id_valid,
  output logic [31:0]                o_id_inst,
  output logic [31:0]                o_id_pc,
  output logic [31:0]                o_id_pc_plus_4,
  input  logic                       i_id_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][31:0] inst_mem_reg;
  logic [DEPTH-1:0][31:0] pc_mem_reg;
  logic [DEPTH-1:0]       wr_en;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic full;
  logic head_valid;
  logic push_write;   // IF word is written into storage
  logic pop_mem;      // head of storage is consumed

  // Stall depends on registered occupancy only, never on i_id_ready.
  assign full       = (count_reg == CNT_W'(DEPTH));
  assign head_valid = (count_reg != '0);
  assign o_if_stall = full;
  assign o_count    = count_reg;
  assign pop_mem    = head_valid && !i_flush && i_id_ready;

`ifdef FETCH_BUFFER_BYPASS_EN
  logic bypass_active;

  // Gated with reset so nothing is presented while reset is held.
  assign bypass_active = i_rst_n && !head_valid && i_if_valid && !i_flush;
  // A bypassed word that ID takes immediately never touches storage.
  assign push_write    = i_if_valid && !full && !i_flush && !(bypass_active && i_id_ready);
  assign o_id_valid    = bypass_active || (head_valid && !i_flush);

  always_comb begin
    o_id_inst = NOP_INST;
    o_id_pc   = '0;
    if (bypass_active) begin
      o_id_inst = i_if_inst;
      o_id_pc   = i_if_pc;
    end else if (o_id_valid) begin
      o_id_inst = inst_mem_reg[rd_ptr_reg];
      o_id_pc   = pc_mem_reg[rd_ptr_reg];
    end
  end
`else
  assign push_write = i_if_valid && !full && !i_flush;
  assign o_id_valid = head_valid && !i_flush;

  always_comb begin
    o_id_inst = NOP_INST;
    o_id_pc   = '0;
    if (o_id_valid) begin
      o_id_inst = inst_mem_reg[rd_ptr_reg];
      o_id_pc   = pc_mem_reg[rd_ptr_reg];
    end
  end
`endif

  assign o_id_pc_plus_4 = o_id_pc + 32'd4;

  // One-hot write enable per storage entry.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push_write && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Pointer/count next state. Flush wins over push and pop; stored words are
  // left in place and simply become unreachable.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (i_flush) begin
      rd_ptr_next = wr_ptr_reg;
      count_next  = '0;
    end else begin
      if (push_write) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop_mem)    rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({push_write, pop_mem})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_reg[i] <= NOP_INST;
        pc_mem_reg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          inst_mem_reg[i] <= i_if_inst;
          pc_mem_reg[i]   <= i_if_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer -- self-checking bench for fetch_buffer.
// A queue-of-words reference model predicts every output each cycle; directed
// sequences cover streaming, fill/stall, pointer wrap, flush, asynchronous
// reset and PC wrap, followed by randomized traffic.
module tb_fetch_buffer;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam int          CNT_W    = $clog2(DEPTH+1);

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_if_valid;
  logic [31:0]      i_if_inst;
  logic [31:0]      i_if_pc;
  logic             o_if_stall;
  logic             i_flush;
  logic             o_id_valid;
  logic [31:0]      o_id_inst;
  logic [31:0]      o_id_pc;
  logic [31:0]      o_id_pc_plus_4;
  logic             i_id_ready;
  logic [CNT_W-1:0] o_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  fetch_buffer #(.DEPTH(DEPTH), .NOP_INST(NOP_INST)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_if_valid     (i_if_valid),
    .i_if_inst      (i_if_inst),
    .i_if_pc        (i_if_pc),
    .o_if_stall     (o_if_stall),
    .i_flush        (i_flush),
    .o_id_valid     (o_id_valid),
    .o_id_inst      (o_id_inst),
    .o_id_pc        (o_id_pc),
    .o_id_pc_plus_4 (o_id_pc_plus_4),
    .i_id_ready     (i_id_ready),
    .o_count        (o_count)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: words in delivery order, each {inst, pc}.
  logic [63:0] model_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1: drive inputs, compare settled outputs against the
  // model, advance the model as the coming edge will, then cross that edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic fl, input logic rdy);
    logic        exp_valid;
    logic [31:0] exp_inst, exp_pc;
    logic        bypassed;
    i_if_valid = v;
    i_if_inst  = inst;
    i_if_pc    = pc;
    i_flush    = fl;
    i_id_ready = rdy;
    #1;
    bypassed  = 1'b0;
    exp_valid = (model_q.size() != 0) && !fl;
    exp_inst  = exp_valid ? model_q[0][63:32] : NOP_INST;
    exp_pc    = exp_valid ? model_q[0][31:0]  : 32'h0;
`ifdef FETCH_BUFFER_BYPASS_EN
    if (model_q.size() == 0 && v && !fl) begin
      bypassed  = 1'b1;
      exp_valid = 1'b1;
      exp_inst  = inst;
      exp_pc    = pc;
    end
`endif
    check("count", 32'(o_count), 32'(model_q.size()));
    check("stall", 32'(o_if_stall), 32'(model_q.size() == DEPTH));
    check("valid", 32'(o_id_valid), 32'(exp_valid));
    check("inst",  o_id_inst, exp_inst);
    check("pc",    o_id_pc, exp_pc);
    check("pc4",   o_id_pc_plus_4, exp_pc + 32'd4);
    $display("txn v=%0d pc=%08h fl=%0d rdy=%0d | out v=%0d pc=%08h cnt=%0d stall=%0d",
             v, pc, fl, rdy, o_id_valid, o_id_pc, o_count, o_if_stall);
    if (fl) begin
      model_q.delete();
    end else if (bypassed) begin
      if (!rdy) model_q.push_back({inst, pc});
    end else begin
      logic can_push;
      can_push = v && (model_q.size() < DEPTH);
      if (exp_valid && rdy) void'(model_q.pop_front());
      if (can_push) model_q.push_back({inst, pc});
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(o_id_valid), 32'h0);
    check({tag, "_count"}, 32'(o_count), 32'h0);
    check({tag, "_stall"}, 32'(o_if_stall), 32'h0);
    check({tag, "_inst"},  o_id_inst, NOP_INST);
    check({tag, "_pc4"},   o_id_pc_plus_4, 32'h4);
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_if_valid = 1'b0;
    i_if_inst  = 32'h0;
    i_if_pc    = 32'h0;
    i_flush    = 1'b0;
    i_id_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs("rst");
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Streaming at occupancy <= 1.
    step(1'b1, 32'hA0000000, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'hA0000001, 32'h4, 1'b0, 1'b1);
    step(1'b1, 32'hA0000002, 32'h8, 1'b0, 1'b1);
    idle_drain();

    // Fill, held third word, release one pop.
    step(1'b1, 32'hB0000000, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'hB0000001, 32'h104, 1'b0, 1'b0);
    step(1'b1, 32'hB0000002, 32'h108, 1'b0, 1'b0);
    step(1'b1, 32'hB0000002, 32'h108, 1'b0, 1'b1);
    step(1'b1, 32'hB0000002, 32'h108, 1'b0, 1'b0);
    idle_drain();

    // Pointer wrap at occupancy 1.
    step(1'b1, 32'hC0000000, 32'h300, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++)
      step(1'b1, 32'hC0000000 + 32'(i), 32'h300 + 32'(4 * i), 1'b0, 1'b1);
    idle_drain();

    // Flush with two queued and one incoming.
    step(1'b1, 32'hD0000000, 32'h1F0, 1'b0, 1'b0);
    step(1'b1, 32'hD0000001, 32'h1F4, 1'b0, 1'b0);
    step(1'b1, 32'hD0000002, 32'h1F8, 1'b1, 1'b1);
    step(1'b1, 32'hD0000003, 32'h200, 1'b0, 1'b0);
    idle_drain();

    // Asynchronous reset with two entries queued.
    step(1'b1, 32'hE0000000, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'hE0000001, 32'h404, 1'b0, 1'b0);
    i_if_valid = 1'b0;
    i_id_ready = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_q.delete();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // PC wrap.
    step(1'b1, 32'hF0000000, 32'hFFFFFFFC, 1'b0, 1'b1);
    idle_drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      pc = {$urandom} & 32'hFFFFFFFC;
      step(1'($urandom_range(0, 3) != 0), $urandom, pc,
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end
    idle_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
